pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline-stage register for the pipelined datapath, the general-purpose successor to the fixed per-stage latch registers between IF/ID/EX/MEM/WB. It carries an arbitrary-width payload, such as a packed control/data bundle, under a valid/ready handshake. A two-entry skid buffer keeps full throughput without a combinational ready path. The block also supports synchronous flush for branch/jump squash and keeps a saturating stall counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: two-entry skid buffer under a valid/ready
// handshake, with synchronous flush and a saturating output-stall counter.
module pipe_stage_reg #(
    parameter int unsigned    DW        = 32,
    parameter logic [DW-1:0]  RESET_VAL = '0,
    parameter int unsigned    CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_main;
    logic [DW-1:0]    r_skid;
    logic [DW-1:0]    w_main_nxt;
    logic [DW-1:0]    w_skid_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Ready depends only on state and flush, never on out_ready.
    assign in_ready   = (r_state != ST_SKID) && !flush;
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_data   = r_main;
    assign stall_cnt  = r_stall_cnt;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        occ = 2'd0;
        case (r_state)
            ST_FULL: occ = 2'd1;
            ST_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RESET_VAL;
            w_skid_nxt  = RESET_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_nxt = in_data;
                    end else if (w_in_xfer) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = in_data;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed phases plus random traffic, checked by a
// queue-based FIFO reference model sampled just before each rising edge.
module tb_pipe_stage_reg;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_reg #(.DW(DW), .RESET_VAL('0), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occ(occ), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DW-1:0] q[$];
    int unsigned   m_stall  = 0;
    bit            clean    = 1'b1;
    bit            acc      = 1'b0;
    int unsigned   emitted  = 0;
    int unsigned   accepted = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks DUT state against the model, then applies this cycle's handshakes.
    always begin
        bit            m_ready;
        bit            in_x;
        bit            out_x;
        logic [DW-1:0] exp_d;
        @(negedge CLK);
        #4;
        if (!nRST) begin
            q.delete();
            m_stall = 0;
            clean   = 1'b1;
            acc     = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_occ", occ, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_stall", stall_cnt, 0);
            chk("rst_in_ready", in_ready, !flush);
        end else begin
            m_ready = (q.size() < 2) && !flush;
            chk("occ", occ, q.size());
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, m_ready);
            chk("stall_cnt", stall_cnt, m_stall);
            if (clean && q.size() == 0) chk("idle_data", out_data, 0);
            in_x  = in_valid && m_ready;
            out_x = (q.size() != 0) && out_ready;
            if (q.size() != 0 && !out_ready && m_stall < SMAX) m_stall++;
            if (out_x) begin
                exp_d = q.pop_front();
                chk("out_data", out_data, exp_d);
                emitted++;
            end
            if (flush) begin
                q.delete();
                clean = 1'b1;
            end else if (in_x) begin
                q.push_back(in_data);
                clean = 1'b0;
                accepted++;
            end
            acc = in_x;
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
        @(negedge CLK);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input int unsigned n, input bit ordy);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] seq[3];
        int unsigned   idx;
        int unsigned   e0;
        int unsigned   k;

        // Reset state
        nRST = 1'b0;
        idle(3, 1'b1);
        @(negedge CLK);
        nRST = 1'b1;

        // Streaming 1..100 at full rate
        e0 = emitted;
        for (int unsigned i = 1; i <= 100; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("stream_count", emitted - e0, 100);

        // Back-pressure: A,B,C with out_ready low; C held until space
        seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hC;
        idx = 0;
        e0  = emitted;
        k   = 0;
        while (emitted - e0 < 3 && k < 60) begin
            @(negedge CLK);
            if (k > 0 && acc) idx++;
            if (k == 5) begin
                #1;
                chk("bp_occ2", occ, 2);
                chk("bp_ready0", in_ready, 0);
            end
            in_valid  = (idx < 3);
            in_data   = (idx < 3) ? seq[idx] : '0;
            out_ready = (k >= 8);
            k++;
        end
        chk("bp_count", emitted - e0, 3);
        idle(2, 1'b1);

        // Flush with occ=2 and a refused 0xDEAD
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("flush_occ", occ, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_keeps_stall", stall_cnt != 0, 1);
        idle(3, 1'b1);

        // Reset mid-stream with occ=2
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        nRST     = 1'b0;
        #1;
        chk("midrst_occ", occ, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_stall", stall_cnt, 0);
        chk("midrst_ready", in_ready, 1);
        @(negedge CLK);
        nRST = 1'b1;

        // Stall counter saturation, survives flush, cleared by reset
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        idle(20, 1'b0);
        #1;
        chk("stall_sat", stall_cnt, SMAX);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("stall_after_flush", stall_cnt, SMAX);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("stall_after_rst", stall_cnt, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic with occasional flush
        for (int unsigned i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 199) == 0));
        end
        idle(4, 1'b1);
        chk("final_occ", occ, 0);
        chk("final_accounting", accepted >= emitted, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
